// File: rtl/replay_ctrl_pkg.sv
// Shared types, default parameters and width helpers for the replay scheduler.
package replay_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT4 = 2'd1,
    WAIT8 = 2'd2
  } state_t;

  localparam int N_DEF        = 10;
  localparam int NREQ_DEF     = 4;
  localparam int S4_DRAIN_DEF = 5;
  localparam int S8_DRAIN_DEF = 9;
  localparam int MAX_RPL_DEF  = 4;
  localparam int THR_CYC_DEF  = 16;
  localparam int RPL_W        = 3;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int DRAIN_W = cnt_w(S4_DRAIN_DEF, S8_DRAIN_DEF);
  localparam int THR_W   = cnt_w(THR_CYC_DEF, THR_CYC_DEF);

endpackage

// File: rtl/replay_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner when enabled.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PTR_W'((int'(idx) + 1) % NREQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/replay_ctrl.sv
// Replay scheduler: arbitrates S4/S8 replay causes, enforces drain blackouts and
// throttles issue when replays repeat without a commit.
module replay_ctrl
  import replay_ctrl_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int S4_DRAIN = S4_DRAIN_DEF,
  parameter int S8_DRAIN = S8_DRAIN_DEF,
  parameter int MAX_RPL  = MAX_RPL_DEF,
  parameter int THR_CYC  = THR_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  s4_req,
  input  logic [NREQ-1:0]  s8_req,
  input  logic             vld_s4,
  input  logic             vld_s8,
  input  logic             commit,
  output logic [NREQ-1:0]  s4_gnt,
  output logic [NREQ-1:0]  s8_gnt,
  output logic             replay_s4_req,
  output logic             replay_s8_req,
  output logic [N-1:0]     stall_req,
  output logic             throttle,
  output logic [RPL_W-1:0] rpl_cnt
);

  localparam int DW = (cnt_w(S4_DRAIN, S8_DRAIN) > DRAIN_W) ? cnt_w(S4_DRAIN, S8_DRAIN) : DRAIN_W;
  localparam int TW = (cnt_w(THR_CYC, THR_CYC) > THR_W) ? cnt_w(THR_CYC, THR_CYC) : THR_W;

  state_t           state_q;
  logic [DW-1:0]    drain_q;
  logic [TW-1:0]    thr_q;
  logic [NREQ-1:0]  s4_gnt_q, s8_gnt_q;
  logic             rep4_q, rep8_q, throttle_q;
  logic [RPL_W-1:0] rpl_q, rpl_d;

  logic [NREQ-1:0]  arb4_gnt, arb8_gnt;
  logic             s4_fire, s8_fire, any_fire, thr_start;

  // S8 wins outright; S4 is only considered from IDLE.
  always_comb begin
    s8_fire   = vld_s8 && (|s8_req) && (state_q != WAIT8);
    s4_fire   = vld_s4 && (|s4_req) && (state_q == IDLE) && !s8_fire;
    any_fire  = s8_fire || s4_fire;
    rpl_d     = rpl_q;
    if (commit) begin
      rpl_d = any_fire ? RPL_W'(1) : '0;
    end else if (any_fire && (rpl_q != '1)) begin
      rpl_d = rpl_q + RPL_W'(1);
    end
    thr_start = any_fire && !throttle_q && (rpl_d == RPL_W'(MAX_RPL));
  end

  rr_arb #(.NREQ(NREQ)) u_arb_s4 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (s4_req),
    .en_i  (s4_fire),
    .gnt_o (arb4_gnt)
  );

  rr_arb #(.NREQ(NREQ)) u_arb_s8 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (s8_req),
    .en_i  (s8_fire),
    .gnt_o (arb8_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      thr_q      <= '0;
      s4_gnt_q   <= '0;
      s8_gnt_q   <= '0;
      rep4_q     <= 1'b0;
      rep8_q     <= 1'b0;
      throttle_q <= 1'b0;
      rpl_q      <= '0;
    end else begin
      s4_gnt_q <= s4_fire ? arb4_gnt : '0;
      s8_gnt_q <= s8_fire ? arb8_gnt : '0;
      rep4_q   <= s4_fire;
      rep8_q   <= s8_fire;
      rpl_q    <= rpl_d;

      if (thr_start) begin
        throttle_q <= 1'b1;
        thr_q      <= TW'(THR_CYC - 1);
      end else if (throttle_q) begin
        if (thr_q == '0) throttle_q <= 1'b0;
        else             thr_q      <= thr_q - TW'(1);
      end

      // The state reads IDLE in the same cycle drain_cnt reaches 0, so a DRAIN of D
      // spaces consecutive grants exactly D cycles apart.
      case (state_q)
        IDLE: begin
          if (s8_fire) begin
            state_q <= WAIT8;
            drain_q <= DW'(S8_DRAIN - 1);
          end else if (s4_fire) begin
            state_q <= WAIT4;
            drain_q <= DW'(S4_DRAIN - 1);
          end
        end
        WAIT4: begin
          if (s8_fire) begin
            state_q <= WAIT8;
            drain_q <= DW'(S8_DRAIN - 1);
          end else if (drain_q <= DW'(1)) begin
            state_q <= IDLE;
            drain_q <= '0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        WAIT8: begin
          if (drain_q <= DW'(1)) begin
            state_q <= IDLE;
            drain_q <= '0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          drain_q <= '0;
        end
      endcase
    end
  end

  assign s4_gnt        = s4_gnt_q;
  assign s8_gnt        = s8_gnt_q;
  assign replay_s4_req = rep4_q;
  assign replay_s8_req = rep8_q;
  assign throttle      = throttle_q;
  assign rpl_cnt       = rpl_q;
  assign stall_req     = {{(N-1){1'b0}}, throttle_q};

endmodule
